// File: rtl/exec_mul_sequencer.sv
// rtl/exec_mul_sequencer.sv - iterative shift-and-add multiplier with EX-stage stall sequencing
// Retires BITS_PER_CYCLE multiplier bits per BUSY cycle; fixed latency regardless of operand values.
module exec_mul_sequencer #(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_E,
  input  logic             flush_E,
  input  logic [WIDTH-1:0] srcA_E,
  input  logic [WIDTH-1:0] srcB_E,
  output logic [WIDTH-1:0] mulResult_E,
  output logic             done_E,
  output logic             busy_E,
  output logic             stall_E
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] partial;
  logic             accept;

  assign accept = (state_q == IDLE) && start_E && !flush_E;

  // Sum of the shifted multiplicands selected by this cycle's multiplier bits
  always_comb begin
    partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mcand_d  = srcA_E;
          mplier_d = srcB_E;
          acc_d    = '0;
          count_d  = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        count_d  = count_q + CW'(1);
        if (count_q == LAST_CNT) begin
          result_d = acc_q + partial;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A squashed instruction never publishes a result
    if (flush_E) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      count_q  <= count_d;
    end
  end

  assign mulResult_E = result_q;
  assign done_E      = (state_q == DONE) && !flush_E;
  assign busy_E      = (state_q != IDLE);
  assign stall_E     = reset && (accept || (state_q == BUSY));

endmodule
